// File: rtl/dram_rd_ctrl.sv
// dram_rd_ctrl -- read-phase stage of the downsampling datapath.
//
// When the master raises rd_en, this block accepts IMG_WORDS pixel words from the
// upstream valid/ready stream. It writes each word to the image DRAM at consecutive
// addresses, starting at BASE_ADDR and wrapping modulo 2**ADDR_W. When every word has
// been written it raises rd_done, which stays high until rd_en drops. If TMO_CYC LOAD
// cycles pass without a handshake, it aborts the phase and raises rd_err.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   rd_en              master request (level, held for the whole phase)
//   in_valid/in_data   upstream word
//   in_ready           word accepted when in_valid & in_ready
//   mem_we/mem_addr/mem_wdata   DRAM write port (one-cycle strobe per word)
//   rd_done            all words written
//   rd_err             stream timeout, phase aborted
//   word_cnt           words accepted in the current phase
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for rd_en; in_ready low
// LOAD  | accepting words; one DRAM write per handshake, latency 1
// FLUSH | one cycle carrying the final write pulse
// DONE  | rd_done held until rd_en drops
// ERR   | timeout seen; rd_err held until rd_en drops

module dram_rd_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 14,
   parameter int IMG_WORDS = 16384,
   parameter int BASE_ADDR = 0,
   parameter int TMO_CYC   = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              rd_done,
   output logic              rd_err,
   output logic [ADDR_W:0]   word_cnt
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int TMO_W = $clog2(TMO_CYC);

   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IMG_WORDS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state, state_n;
   logic [TMO_W-1:0]  tmo, tmo_n;
   logic              in_ready_n, mem_we_n, rd_done_n, rd_err_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_wdata_n;
   logic [CNT_W-1:0]  word_cnt_n;
   logic              hs;

   assign hs = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         tmo       <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE;
         mem_wdata <= '0;
         rd_done   <= 1'b0;
         rd_err    <= 1'b0;
         word_cnt  <= '0;
      end else begin
         state     <= state_n;
         tmo       <= tmo_n;
         in_ready  <= in_ready_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         rd_done   <= rd_done_n;
         rd_err    <= rd_err_n;
         word_cnt  <= word_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      tmo_n       = tmo;
      in_ready_n  = in_ready;
      mem_we_n    = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      rd_done_n   = rd_done;
      rd_err_n    = rd_err;
      word_cnt_n  = word_cnt;

      unique case (state)
         S_IDLE: begin
            in_ready_n = 1'b0;
            if (rd_en) begin
               state_n    = S_LOAD;
               word_cnt_n = '0;
               tmo_n      = '0;
               in_ready_n = 1'b1;
            end
         end

         S_LOAD: begin
            // A word accepted on this edge is written even if the phase ends here.
            if (hs) begin
               mem_we_n    = 1'b1;
               mem_addr_n  = BASE + word_cnt[ADDR_W-1:0];
               mem_wdata_n = in_data;
               word_cnt_n  = word_cnt + CNT_W'(1);
               tmo_n       = '0;
            end else begin
               tmo_n = tmo + TMO_W'(1);
            end

            // Abort outranks completion and timeout.
            if (!rd_en) begin
               state_n    = S_IDLE;
               in_ready_n = 1'b0;
            end else if (hs && word_cnt == LAST_CNT) begin
               state_n    = S_FLUSH;
               in_ready_n = 1'b0;
            end else if (!hs && tmo == TMO_LAST) begin
               state_n    = S_ERR;
               in_ready_n = 1'b0;
               rd_err_n   = 1'b1;
            end
         end

         S_FLUSH: begin
            state_n   = S_DONE;
            rd_done_n = 1'b1;
         end

         S_DONE: begin
            if (!rd_en) begin
               state_n   = S_IDLE;
               rd_done_n = 1'b0;
            end
         end

         S_ERR: begin
            if (!rd_en) begin
               state_n  = S_IDLE;
               rd_err_n = 1'b0;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dram_rd_ctrl.sv
// Directed bench for dram_rd_ctrl. It uses two instances. The main instance has
// IMG_WORDS=4, BASE_ADDR=0x10 and TMO_CYC=8. The wrap instance has ADDR_W=2,
// IMG_WORDS=4 and BASE_ADDR=2. Inputs change and outputs are sampled 1 ns after each
// rising edge.

module tb_dram_rd_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_en, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, rd_done, rd_err;
   logic [13:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [14:0] word_cnt;

   logic        rd_en2, in_valid2;
   logic [7:0]  in_data2;
   logic        in_ready2, mem_we2, rd_done2, rd_err2;
   logic [1:0]  mem_addr2;
   logic [7:0]  mem_wdata2;
   logic [2:0]  word_cnt2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dram_rd_ctrl #(.DATA_W(8), .ADDR_W(14), .IMG_WORDS(4), .BASE_ADDR(16), .TMO_CYC(8)) u_dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rd_done(rd_done), .rd_err(rd_err), .word_cnt(word_cnt)
   );

   dram_rd_ctrl #(.DATA_W(8), .ADDR_W(2), .IMG_WORDS(4), .BASE_ADDR(2), .TMO_CYC(16)) u_wrap (
      .clk(clk), .reset(reset), .rd_en(rd_en2), .in_valid(in_valid2), .in_data(in_data2),
      .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .rd_done(rd_done2), .rd_err(rd_err2), .word_cnt(word_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      reset = 1'b1; rd_en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      rd_en2 = 1'b0; in_valid2 = 1'b0; in_data2 = 8'h00;
      step(); step();
      reset = 1'b0;

      // reset values
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 32'h10);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rd_done", rd_done, 0);
      chk("rst_rd_err", rd_err, 0);
      chk("rst_word_cnt", word_cnt, 0);

      // T1: continuous stream; in_valid in IDLE must be ignored
      rd_en = 1'b1; in_valid = 1'b1; in_data = 8'h99;
      step();
      chk("t1_ready_load", in_ready, 1);
      chk("t1_no_we_idle", mem_we, 0);
      for (int i = 0; i < 4; i++) begin
         in_data = 8'hA0 + 8'(i);
         step();
         chk("t1_we", mem_we, 1);
         chk("t1_addr", mem_addr, 32'h10 + i);
         chk("t1_data", mem_wdata, 32'hA0 + i);
         chk("t1_cnt", word_cnt, i + 1);
      end
      chk("t1_ready_low", in_ready, 0);
      chk("t1_done_not_yet", rd_done, 0);
      in_data = 8'hEE;
      step();
      chk("t1_done", rd_done, 1);
      chk("t1_no_extra_we", mem_we, 0);
      step();
      chk("t1_done_hold", rd_done, 1);
      chk("t1_cnt_hold", word_cnt, 4);
      rd_en = 1'b0; in_valid = 1'b0;
      step();
      chk("t1_done_clr", rd_done, 0);
      step();

      // T2: in_valid toggling
      rd_en = 1'b1; in_valid = 1'b0;
      step();
      k = 0;
      for (int c = 0; c < 7; c++) begin
         in_valid = (c % 2 == 0);
         in_data  = 8'hB0 + 8'(k);
         step();
         if (c % 2 == 0) begin
            chk("t2_we", mem_we, 1);
            chk("t2_addr", mem_addr, 32'h10 + k);
            chk("t2_data", mem_wdata, 32'hB0 + k);
            k++;
         end else begin
            chk("t2_no_we", mem_we, 0);
         end
      end
      chk("t2_ready_low", in_ready, 0);
      in_valid = 1'b1; in_data = 8'hEE;
      step();
      chk("t2_no_extra_we", mem_we, 0);
      chk("t2_done", rd_done, 1);
      step();
      chk("t2_no_extra_we2", mem_we, 0);
      chk("t2_cnt", word_cnt, 4);
      rd_en = 1'b0; in_valid = 1'b0;
      step(); step();

      // T3: timeout after 2 words
      rd_en = 1'b1; in_valid = 1'b1; in_data = 8'hC0;
      step();
      step(); in_data = 8'hC1;
      step();
      chk("t3_cnt2", word_cnt, 2);
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("t3_no_err_yet", rd_err, 0);
         chk("t3_ready_yet", in_ready, 1);
      end
      step();
      chk("t3_err", rd_err, 1);
      chk("t3_ready_low", in_ready, 0);
      chk("t3_no_done", rd_done, 0);
      in_valid = 1'b1;
      step(); step();
      chk("t3_err_hold", rd_err, 1);
      chk("t3_no_done2", rd_done, 0);
      chk("t3_no_we_err", mem_we, 0);
      rd_en = 1'b0; in_valid = 1'b0;
      step();
      chk("t3_err_clr", rd_err, 0);
      step();
      rd_en = 1'b1; in_valid = 1'b1; in_data = 8'hC8;
      step();
      chk("t3_restart_cnt", word_cnt, 0);
      chk("t3_restart_ready", in_ready, 1);
      step();
      chk("t3_restart_addr", mem_addr, 32'h10);
      chk("t3_restart_we", mem_we, 1);
      rd_en = 1'b0; in_valid = 1'b0;
      step(); step();

      // T4: abort after 2 words, word accepted on the abort edge is still written
      rd_en = 1'b1; in_valid = 1'b1; in_data = 8'hD0;
      step();
      step(); in_data = 8'hD1;
      step();
      chk("t4_addr1", mem_addr, 32'h11);
      rd_en = 1'b0; in_data = 8'hD2;
      step();
      chk("t4_abort_we", mem_we, 1);
      chk("t4_abort_addr", mem_addr, 32'h12);
      chk("t4_abort_data", mem_wdata, 32'hD2);
      chk("t4_abort_ready", in_ready, 0);
      chk("t4_abort_cnt", word_cnt, 3);
      step();
      chk("t4_after_we", mem_we, 0);
      chk("t4_no_done", rd_done, 0);
      step();
      chk("t4_no_done2", rd_done, 0);
      rd_en = 1'b1; in_data = 8'hD8;
      step();
      chk("t4_reload_cnt", word_cnt, 0);
      step();
      chk("t4_reload_addr", mem_addr, 32'h10);
      chk("t4_reload_data", mem_wdata, 32'hD8);
      rd_en = 1'b0; in_valid = 1'b0;
      step(); step();

      // T5: reset with a pending write, then reset in DONE
      rd_en = 1'b1; in_valid = 1'b1; in_data = 8'hE0;
      step();
      step(); in_data = 8'hE1;
      reset = 1'b1;
      step();
      chk("t5_we", mem_we, 0);
      chk("t5_ready", in_ready, 0);
      chk("t5_addr", mem_addr, 32'h10);
      chk("t5_data", mem_wdata, 0);
      chk("t5_cnt", word_cnt, 0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("t5_done_reached", rd_done, 1);
      reset = 1'b1;
      step();
      chk("t5_done_rst", rd_done, 0);
      reset = 1'b0; rd_en = 1'b0; in_valid = 1'b0;
      step();

      // T6: address wrap on the 2-bit instance
      rd_en2 = 1'b1; in_valid2 = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         in_data2 = 8'h60 + 8'(i);
         step();
         chk("t6_we", mem_we2, 1);
         chk("t6_addr", mem_addr2, (2 + i) % 4);
         chk("t6_data", mem_wdata2, 32'h60 + i);
      end
      step();
      chk("t6_done", rd_done2, 1);
      chk("t6_cnt", word_cnt2, 4);
      chk("t6_no_err", rd_err2, 0);
      rd_en2 = 1'b0;
      step();
      chk("t6_done_clr", rd_done2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
